// File: rtl/mux_pkg.sv
// Select encodings shared by the 4:1 selector and its core.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  // Pack the two select pins into the select code (a is the MSB).
  function automatic sel_t sel_of(input logic a, input logic b);
    return {a, b};
  endfunction

endpackage

// File: rtl/mux4_core.sv
// Combinational 4-way selector core. Every data bit is steered by the same
// select; an unknown select yields all-X rather than a silent pick.
module mux4_core
  import mux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  sel_t              sel,
  input  logic [DATA_W-1:0] da,
  input  logic [DATA_W-1:0] db,
  input  logic [DATA_W-1:0] dc,
  input  logic [DATA_W-1:0] dd,
  output logic [DATA_W-1:0] y
);

  // Select one input; the default arm only fires for X/Z selects in simulation.
  always_comb begin
    y = 'x;
    case (sel)
      SEL_A:   y = da;
      SEL_B:   y = db;
      SEL_C:   y = dc;
      SEL_D:   y = dd;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux4to1.sv
// 4:1 data selector with an optional async-reset output register.
// OUT_REG=1 retimes Out to clk (1-cycle latency, cleared while rst_n is low);
// OUT_REG=0 passes the core output straight through and ignores clk/rst_n.
module mux4to1
  import mux_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a,
  input  logic              b,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] C,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Out
);

  sel_t              sel_p0;
  logic [DATA_W-1:0] mux_p0;

  assign sel_p0 = sel_of(a, b);

  mux4_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .sel(sel_p0),
    .da (A),
    .db (B),
    .dc (C),
    .dd (D),
    .y  (mux_p0)
  );

  generate
    if (OUT_REG) begin : g_reg
      logic [DATA_W-1:0] out_p1;

      // Stage p0 -> p1: capture the selected value; async clear to zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_p1 <= '0;
        else        out_p1 <= mux_p0;
      end

      assign Out = out_p1;
    end else begin : g_comb
      assign Out = mux_p0;
    end
  endgenerate

endmodule

// File: tb/tb_mux4to1.sv
// Bench for mux4to1: registered 1-bit and 4-bit instances plus a
// combinational 4-bit instance, driven by directed vector tables.
module tb_mux4to1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic comb_rst_n = 1'b1;

  // 1-bit registered instance
  logic a1 = 0, b1 = 0, A1 = 0, B1 = 0, C1 = 0, D1 = 0;
  logic out1;
  // 4-bit registered instance
  logic a4 = 0, b4 = 0;
  logic [3:0] A4 = 4'h1, B4 = 4'h2, C4 = 4'h4, D4 = 4'h8;
  logic [3:0] out4;
  // 4-bit combinational instance
  logic ac = 0, bc = 0;
  logic [3:0] Ac = 4'h3, Bc = 4'h5, Cc = 4'hA, Dc = 4'hC;
  logic [3:0] outc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux4to1 #(.DATA_W(1), .OUT_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
    .A(A1), .B(B1), .C(C1), .D(D1), .Out(out1));

  mux4to1 #(.DATA_W(4), .OUT_REG(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
    .A(A4), .B(B4), .C(C4), .D(D4), .Out(out4));

  mux4to1 #(.DATA_W(4), .OUT_REG(1'b0)) u_comb (
    .clk(clk), .rst_n(comb_rst_n), .a(ac), .b(bc),
    .A(Ac), .B(Bc), .C(Cc), .D(Dc), .Out(outc));

  typedef struct {
    logic a, b;
    logic A, B, C, D;
    logic exp;
  } vec1_t;

  typedef struct {
    logic       a, b;
    logic [3:0] exp;
  } vec4_t;

  typedef struct {
    logic       a, b;
    logic [3:0] exp;
  } vecc_t;

  vec1_t tbl1[64];
  vec4_t tbl4[4];
  vecc_t tblc[4];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Truth table for the 1-bit instance: index i = {a,b,A,B,C,D}.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      logic [3:0] data;
      v = i[5:0];
      tbl1[i].a = v[5];
      tbl1[i].b = v[4];
      tbl1[i].A = v[3];
      tbl1[i].B = v[2];
      tbl1[i].C = v[1];
      tbl1[i].D = v[0];
      data = {v[0], v[1], v[2], v[3]};  // {D,C,B,A}
      tbl1[i].exp = data[v[5:4]];
    end
    tbl4[0] = '{a: 0, b: 0, exp: 4'h1};
    tbl4[1] = '{a: 0, b: 1, exp: 4'h2};
    tbl4[2] = '{a: 1, b: 0, exp: 4'h4};
    tbl4[3] = '{a: 1, b: 1, exp: 4'h8};
    tblc[0] = '{a: 0, b: 0, exp: 4'h3};
    tblc[1] = '{a: 0, b: 1, exp: 4'h5};
    tblc[2] = '{a: 1, b: 0, exp: 4'hA};
    tblc[3] = '{a: 1, b: 1, exp: 4'hC};

    // Reset held from time 0: registered outputs clear.
    #2;
    check("reset_init_1b", {3'b0, out1}, 4'h0);
    check("reset_init_4b", out4, 4'h0);

    // Test 1: load 1 with reset released, then assert reset mid-cycle.
    @(negedge clk);
    rst_n = 1; A1 = 1; B1 = 1; C1 = 1; D1 = 1; a1 = 0; b1 = 0;
    @(posedge clk); #1;
    check("pre_reset_load", {3'b0, out1}, 4'h1);
    #2;
    rst_n = 0;
    #1;
    check("async_reset_immediate", {3'b0, out1}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {3'b0, out1}, 4'h0);
    @(negedge clk);
    #2 rst_n = 1;   // deassert off the edges
    @(posedge clk); #1;
    check("first_edge_after_reset", {3'b0, out1}, 4'h1);

    // Test 2: 4-bit exhaustive select, one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a4 = tbl4[i].a; b4 = tbl4[i].b;
      #1;
      if (i > 0) check($sformatf("sel4_hold_%0d", i), out4, tbl4[i-1].exp);
      @(posedge clk); #1;
      check($sformatf("sel4_%0d", i), out4, tbl4[i].exp);
    end

    // Test 3: 1-bit truth table.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      a1 = tbl1[i].a; b1 = tbl1[i].b;
      A1 = tbl1[i].A; B1 = tbl1[i].B; C1 = tbl1[i].C; D1 = tbl1[i].D;
      @(posedge clk); #1;
      check($sformatf("truth_%0d", i), {3'b0, out1}, {3'b0, tbl1[i].exp});
    end

    // Test 4: glitches on B between edges are invisible.
    @(negedge clk);
    a1 = 0; b1 = 1; B1 = 0;
    @(posedge clk); #1;
    check("glitch_base", {3'b0, out1}, 4'h0);
    #1 B1 = 1;
    #1 B1 = 0;
    #1 B1 = 1;
    #1;
    check("glitch_between_edges", {3'b0, out1}, 4'h0);
    @(posedge clk); #1;
    check("glitch_after_edge", {3'b0, out1}, 4'h1);

    // Test 5: select and data change at the same edge.
    @(negedge clk);
    a1 = 0; b1 = 0; A1 = 0; D1 = 0;
    @(posedge clk); #1;
    check("simul_base", {3'b0, out1}, 4'h0);
    @(negedge clk);
    a1 = 1; b1 = 1; D1 = 1;
    @(posedge clk); #1;
    check("simul_change", {3'b0, out1}, 4'h1);

    // Test 6: combinational instance tracks within the timestep.
    for (int i = 0; i < 4; i++) begin
      ac = tblc[i].a; bc = tblc[i].b;
      #1;
      check($sformatf("comb_sel_%0d", i), outc, tblc[i].exp);
    end
    comb_rst_n = 0;
    #1;
    check("comb_rst_ignored", outc, 4'hC);
    ac = 0; bc = 1;
    #1;
    check("comb_track_in_rst", outc, 4'h5);
    Bc = 4'h9;
    #1;
    check("comb_data_follow", outc, 4'h9);
    comb_rst_n = 1;
    @(posedge clk); #1;
    check("comb_clk_ignored", outc, 4'h9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
